// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DMA  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: bit 0 is the CPU, bit 1 the DMA port.
// On a tie the side that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_dma_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_dma_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory between the CPU and a DMA/loader port; each access runs
// IDLE -> ACCESS -> (WAIT) -> DONE and ends with a one-cycle ready pulse.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  localparam int CW = 3;

  state_t          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic            last_dma_q, last_dma_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]   dma_rdata_q, dma_rdata_d;
  logic            cpu_ready_q, cpu_ready_d;
  logic            dma_ready_q, dma_ready_d;
  logic [CW-1:0]   lat_cnt_q, lat_cnt_d;
  logic [1:0]      gnt;

  rr_arb2 u_rr_arb2 (
    .req_i      ({dma_req, cpu_req}),
    .last_dma_i (last_dma_q),
    .gnt_o      (gnt)
  );

  always_comb begin
    // NOTE: every *_d gets its hold value first, so no path through the case
    // leaves a variable unassigned and no latch is inferred.
    state_d     = state_q;
    owner_d     = owner_q;
    last_dma_d  = last_dma_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cpu_ready_d = 1'b0;
    dma_ready_d = 1'b0;
    lat_cnt_d   = lat_cnt_q;

    case (state_q)
      IDLE: begin
        if (gnt[0]) begin
          owner_d = OWN_CPU;
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = ACCESS;
        end else if (gnt[1]) begin
          owner_d = OWN_DMA;
          we_d    = dma_we;
          addr_d  = dma_addr;
          wdata_d = dma_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q || MEM_LAT == 1) begin
          state_d = DONE;
        end else begin
          lat_cnt_d = CW'(MEM_LAT - 1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q - CW'(1);
        if (lat_cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        // Read data is valid on mem_rdata in this cycle; capturing it on the
        // same edge that raises ready makes rdata valid during ready.
        if (owner_q == OWN_CPU) begin
          cpu_ready_d = 1'b1;
          if (!we_q) cpu_rdata_d = mem_rdata;
        end else begin
          dma_ready_d = 1'b1;
          if (!we_q) dma_rdata_d = mem_rdata;
        end
        last_dma_d = (owner_q == OWN_DMA);
        owner_d    = OWN_NONE;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      last_dma_q  <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      lat_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_dma_q  <= last_dma_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      dma_ready_q <= dma_ready_d;
      lat_cnt_q   <= lat_cnt_d;
    end
  end

  // Only mem_en qualifies the memory; the other mem_* hold the latched access.
  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign owner     = owner_q;
  assign cpu_ready = cpu_ready_q;
  assign dma_ready = dma_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule
